aq_mem_arbiter: RTL

- Single-port arbiter for the 64KB system RAM block.
- Shares the RAM between three requesters:
  - CPU/PLA path, highest priority, strobed by the CPU clock enable.
  - Cartridge/tape loader writes from the HPS download stream.
  - Tape playback read engine.
- Sits between the requesters and one synchronous single-port RAM with 1-cycle read latency.
- Replaces dual-port RAM instances so the RAM can move to single-port or external memory.

---
 rtl/aq_mem_arbiter.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/aq_mem_arbiter.sv
// aq_mem_arbiter: single-port arbiter for the 64KB system RAM.
// Requesters: CPU/PLA (highest priority, gated by cpu_ce), loader write FIFO
// and tape read engine (round-robin between the latter two).
// RAM interface is registered; read data returns one cycle after ram_en.
// Optional stall statistics: define AQ_MEM_ARB_STATS_EN.
module aq_mem_arbiter #(
    parameter int unsigned AW       = 16,
    parameter int unsigned DW       = 8,
    parameter int unsigned LD_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cpu_ce,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    input  logic          ld_wr,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_busy,
    output logic          ld_ovf,
    input  logic          tp_req,
    input  logic [AW-1:0] tp_addr,
    output logic          tp_ack,
    output logic [DW-1:0] tp_rdata,
    output logic          tp_rvalid,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we,
    output logic          ram_en,
`ifdef AQ_MEM_ARB_STATS_EN
    output logic [15:0]   stat_ld_stall,
    output logic [15:0]   stat_tp_stall,
`endif
    input  logic [DW-1:0] ram_rdata
);

    localparam int unsigned PW = $clog2(LD_DEPTH);
    localparam int unsigned CW = PW + 1;

    // Owner of the read issued in a pipeline stage
    typedef enum logic [1:0] {TagNone, TagCpu, TagTape} tag_e;

    logic [AW-1:0] fifo_addr_q [LD_DEPTH];
    logic [DW-1:0] fifo_data_q [LD_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          rr_tape_q;
    logic          ovf_q;
    tag_e          s1_tag_q, s2_tag_q, tag_d;
    logic          en_q, we_q, en_d, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] cpu_rdata_q, tp_hold_q;

    logic cpu_win, ld_pend, tp_pend, ld_win, tp_win, fifo_full, push;

    assign cpu_win   = cpu_ce & cpu_req;
    assign ld_pend   = (count_q != '0);
    // A request seen while its own ack is out is the old one; new one is eligible next cycle
    assign tp_pend   = tp_req & (s1_tag_q != TagTape);
    assign ld_win    = ~cpu_win & ld_pend & (~tp_pend | rr_tape_q);
    assign tp_win    = ~cpu_win & tp_pend & ~ld_win;
    assign fifo_full = (count_q == CW'(LD_DEPTH));
    assign push      = ld_wr & (~fifo_full | ld_win);

    // Select the winner's access for the registered RAM port
    always_comb begin
        en_d    = 1'b0;
        we_d    = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
        tag_d   = TagNone;
        if (cpu_win) begin
            en_d    = 1'b1;
            we_d    = cpu_we;
            addr_d  = cpu_addr;
            wdata_d = cpu_we ? cpu_wdata : '0;
            tag_d   = cpu_we ? TagNone : TagCpu;
        end else if (ld_win) begin
            en_d    = 1'b1;
            we_d    = 1'b1;
            addr_d  = fifo_addr_q[rd_ptr_q];
            wdata_d = fifo_data_q[rd_ptr_q];
        end else if (tp_win) begin
            en_d    = 1'b1;
            addr_d  = tp_addr;
            tag_d   = TagTape;
        end
    end

    // Loader FIFO storage, no reset needed since count gates reads
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= ld_addr;
            fifo_data_q[wr_ptr_q] <= ld_wdata;
        end
    end

    // FIFO pointers, occupancy, overflow flag and round-robin state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            rr_tape_q <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (ld_win) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(ld_win);
            if (ld_wr && fifo_full && !ld_win) begin
                ovf_q <= 1'b1;
            end
            if (ld_win) begin
                rr_tape_q <= 1'b0;
            end else if (tp_win) begin
                rr_tape_q <= 1'b1;
            end
        end
    end

    // RAM port registers and read-return pipeline
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_q        <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            s1_tag_q    <= TagNone;
            s2_tag_q    <= TagNone;
            cpu_rdata_q <= '0;
            tp_hold_q   <= '0;
        end else begin
            en_q     <= en_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            s1_tag_q <= tag_d;
            s2_tag_q <= s1_tag_q;
            if (s2_tag_q == TagCpu) begin
                cpu_rdata_q <= ram_rdata;
            end
            if (s2_tag_q == TagTape) begin
                tp_hold_q <= ram_rdata;
            end
        end
    end

    assign ram_en    = en_q;
    assign ram_we    = we_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign cpu_rdata = cpu_rdata_q;
    assign tp_ack    = (s1_tag_q == TagTape);
    assign tp_rvalid = (s2_tag_q == TagTape);
    assign tp_rdata  = tp_rvalid ? ram_rdata : tp_hold_q;
    assign ld_busy   = ld_pend;
    assign ld_ovf    = ovf_q;

`ifdef AQ_MEM_ARB_STATS_EN
    logic [15:0] stat_ld_q, stat_tp_q;

    // Saturating counts of cycles pending but not granted
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_ld_q <= '0;
            stat_tp_q <= '0;
        end else begin
            if (ld_pend && !ld_win && stat_ld_q != 16'hFFFF) begin
                stat_ld_q <= stat_ld_q + 16'd1;
            end
            if (tp_pend && !tp_win && stat_tp_q != 16'hFFFF) begin
                stat_tp_q <= stat_tp_q + 16'd1;
            end
        end
    end

    assign stat_ld_stall = stat_ld_q;
    assign stat_tp_stall = stat_tp_q;
`endif

endmodule
